// File: rtl/fb_pixel_writer.sv
// fb_pixel_writer: writes renderer pixels into the back bank of a
// double-buffered framebuffer. A bank swap (hold_frame toggle) clears the
// new back bank to black before queued pixels are drained into it.
//
// Optional feature macro: FB_STATS_EN
//   defined   -> dropped_count and clear_overrun are live statistics
//   undefined -> both outputs are tied to zero and their registers removed
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | waiting; starts a clear on swap, otherwise pops a pixel
// ST_CALC  | range check and row*H_SIZE+col address computation
// ST_WRITE | pixel write presented until mem_ready
// ST_CLEAR | writing zero to every address of the back bank
module fb_pixel_writer #(
  parameter int H_SIZE     = 720,
  parameter int V_SIZE     = 720,
  parameter int ADDR_W     = 19,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk_vga,
  input  logic              reset_n,
  input  logic              hold_frame,
  input  logic              pix_valid,
  output logic              pix_ready,
  input  logic [10:0]       pix_x,
  input  logic [10:0]       pix_y,
  input  logic [23:0]       pix_color,
  output logic              mem_wr_en,
  output logic              mem_bank,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [23:0]       mem_wdata,
  input  logic              mem_ready,
  output logic              busy_clear,
  output logic [15:0]       dropped_count,
  output logic              clear_overrun
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int ENT_W = 11 + 11 + 24;
  localparam logic [PTR_W:0]    FULL_CNT  = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [10:0]       H_LIM     = 11'(H_SIZE);
  localparam logic [10:0]       V_LIM     = 11'(V_SIZE);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_SIZE * V_SIZE - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_WRITE, ST_CLEAR} state_t;

  // Row base address as a sum of shifted copies of the row, one per set bit
  // of H_SIZE (720 -> y<<9 + y<<7 + y<<6 + y<<4); no multiplier is built.
  function automatic logic [ADDR_W-1:0] row_base(input logic [10:0] y);
    logic [ADDR_W-1:0] acc;
    logic [ADDR_W-1:0] ext;
    acc = '0;
    ext = ADDR_W'(y);
    for (int b = 0; b < 31; b++) begin
      if (H_SIZE[b]) acc = acc + (ext << b);
    end
    return acc;
  endfunction

  // ---------------- pixel FIFO ----------------
  logic [ENT_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             pix_ready_q, pix_ready_d;
  logic             push, pop, fifo_empty;
  logic [ENT_W-1:0] head;

  assign push       = pix_valid && pix_ready_q;
  assign fifo_empty = (count_q == '0);
  assign head       = fifo_mem[rd_ptr_q];
  assign pix_ready  = pix_ready_q;

  // FIFO pointer/level update; ready is derived from the next level so it
  // never advertises space that the same edge just consumed.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
    pix_ready_d = (count_d != FULL_CNT);
  end

  // FIFO storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk_vga) begin
    if (push) fifo_mem[wr_ptr_q] <= {pix_x, pix_y, pix_color};
  end

  // FIFO control registers.
  always_ff @(posedge clk_vga or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      pix_ready_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      pix_ready_q <= pix_ready_d;
    end
  end

  // ---------------- write FSM ----------------
  state_t            state_q, state_d;
  logic [10:0]       px_q, px_d, py_q, py_d;
  logic [23:0]       pc_q, pc_d;
  logic              wr_en_q, wr_en_d;
  logic              bank_q, bank_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [23:0]       wdata_q, wdata_d;
  logic              busy_q, busy_d;
  logic              swap_pend_q, swap_pend_d;
  logic              hold_q, hold_d;
  logic              swap, begin_clear, out_of_range;
  logic [ADDR_W-1:0] calc_addr;

  assign swap         = (hold_frame != hold_q);
  assign out_of_range = (px_q >= H_LIM) || (py_q >= V_LIM);
  assign calc_addr    = row_base(py_q) + ADDR_W'(px_q);

  // Next-state and output computation.
  always_comb begin
    state_d     = state_q;
    px_d        = px_q;
    py_d        = py_q;
    pc_d        = pc_q;
    wr_en_d     = wr_en_q;
    bank_d      = bank_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    busy_d      = busy_q;
    swap_pend_d = swap_pend_q;
    hold_d      = hold_frame;
    pop         = 1'b0;
    begin_clear = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Outside a clear the back bank simply follows ~hold_frame; this also
        // settles the bank select after reset when no swap has happened yet.
        bank_d = ~hold_frame;
        if (swap || swap_pend_q) begin
          begin_clear = 1'b1;
        end else if (!fifo_empty) begin
          pop                = 1'b1;
          {px_d, py_d, pc_d} = head;
          state_d            = ST_CALC;
        end
      end
      ST_CALC: begin
        if (swap) swap_pend_d = 1'b1;
        if (out_of_range) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WRITE;
          wr_en_d = 1'b1;
          addr_d  = calc_addr;
          wdata_d = pc_q;
        end
      end
      ST_WRITE: begin
        if (swap) swap_pend_d = 1'b1;
        if (mem_ready) begin
          wr_en_d = 1'b0;
          if (swap || swap_pend_q) begin_clear = 1'b1;
          else                     state_d     = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        if (swap) begin
          begin_clear = 1'b1;
        end else if (mem_ready) begin
          if (addr_q == LAST_ADDR) begin
            wr_en_d = 1'b0;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Starting (or restarting) a clear always latches the new back bank and
    // rewinds to address 0.
    if (begin_clear) begin
      state_d     = ST_CLEAR;
      bank_d      = ~hold_frame;
      addr_d      = '0;
      wdata_d     = '0;
      wr_en_d     = 1'b1;
      busy_d      = 1'b1;
      swap_pend_d = 1'b0;
    end
  end

  // FSM and memory-interface registers.
  always_ff @(posedge clk_vga or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      px_q        <= '0;
      py_q        <= '0;
      pc_q        <= '0;
      wr_en_q     <= 1'b0;
      bank_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      busy_q      <= 1'b0;
      swap_pend_q <= 1'b0;
      hold_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      px_q        <= px_d;
      py_q        <= py_d;
      pc_q        <= pc_d;
      wr_en_q     <= wr_en_d;
      bank_q      <= bank_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      busy_q      <= busy_d;
      swap_pend_q <= swap_pend_d;
      hold_q      <= hold_d;
    end
  end

  assign mem_wr_en  = wr_en_q;
  assign mem_bank   = bank_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign busy_clear = busy_q;

`ifdef FB_STATS_EN
  logic [15:0] dropped_q, dropped_d;
  logic        overrun_q, overrun_d;

  // Saturating drop counter and sticky mid-clear swap flag.
  always_comb begin
    dropped_d = dropped_q;
    if ((state_q == ST_CALC) && out_of_range && (dropped_q != 16'hFFFF))
      dropped_d = dropped_q + 16'd1;
    overrun_d = overrun_q | ((state_q == ST_CLEAR) && swap);
  end

  // Statistics registers.
  always_ff @(posedge clk_vga or negedge reset_n) begin
    if (!reset_n) begin
      dropped_q <= '0;
      overrun_q <= 1'b0;
    end else begin
      dropped_q <= dropped_d;
      overrun_q <= overrun_d;
    end
  end

  assign dropped_count = dropped_q;
  assign clear_overrun = overrun_q;
`else
  assign dropped_count = '0;
  assign clear_overrun = 1'b0;
`endif

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Bench for fb_pixel_writer. dut_f uses the full 720x720 geometry for address
// arithmetic; dut_s uses a 24x20 geometry so whole-bank clears stay short.
module tb_fb_pixel_writer;

  logic clk_vga = 1'b0;
  always #5 clk_vga = ~clk_vga;

  logic reset_n;
  int   cyc = 0;
  always @(posedge clk_vga) cyc++;

  // small instance
  logic        s_hold, s_valid, s_ready, s_wr_en, s_bank, s_mem_ready, s_busy, s_overrun;
  logic [10:0] s_x, s_y;
  logic [23:0] s_color, s_wdata;
  logic [18:0] s_addr;
  logic [15:0] s_dropped;
  // full-size instance
  logic        f_hold, f_valid, f_ready, f_wr_en, f_bank, f_mem_ready, f_busy, f_overrun;
  logic [10:0] f_x, f_y;
  logic [23:0] f_color, f_wdata;
  logic [18:0] f_addr;
  logic [15:0] f_dropped;

  fb_pixel_writer #(.H_SIZE(24), .V_SIZE(20), .ADDR_W(19), .FIFO_DEPTH(16)) dut_s (
    .clk_vga(clk_vga), .reset_n(reset_n), .hold_frame(s_hold),
    .pix_valid(s_valid), .pix_ready(s_ready), .pix_x(s_x), .pix_y(s_y),
    .pix_color(s_color), .mem_wr_en(s_wr_en), .mem_bank(s_bank),
    .mem_addr(s_addr), .mem_wdata(s_wdata), .mem_ready(s_mem_ready),
    .busy_clear(s_busy), .dropped_count(s_dropped), .clear_overrun(s_overrun)
  );

  fb_pixel_writer dut_f (
    .clk_vga(clk_vga), .reset_n(reset_n), .hold_frame(f_hold),
    .pix_valid(f_valid), .pix_ready(f_ready), .pix_x(f_x), .pix_y(f_y),
    .pix_color(f_color), .mem_wr_en(f_wr_en), .mem_bank(f_bank),
    .mem_addr(f_addr), .mem_wdata(f_wdata), .mem_ready(f_mem_ready),
    .busy_clear(f_busy), .dropped_count(f_dropped), .clear_overrun(f_overrun)
  );

`ifdef FB_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  typedef struct {
    logic        bank;
    logic [18:0] addr;
    logic [23:0] data;
    int          cyc;
  } wr_t;
  wr_t sq[$];
  wr_t fq[$];

  // record every accepted memory write
  always @(negedge clk_vga) begin
    wr_t w;
    if (reset_n && s_wr_en && s_mem_ready) begin
      w.bank = s_bank; w.addr = s_addr; w.data = s_wdata; w.cyc = cyc;
      sq.push_back(w);
    end
    if (reset_n && f_wr_en && f_mem_ready) begin
      w.bank = f_bank; w.addr = f_addr; w.data = f_wdata; w.cyc = cyc;
      fq.push_back(w);
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_vga);
    #1;
  endtask

  task automatic push_f(input logic [10:0] x, input logic [10:0] y, input logic [23:0] c);
    bit ok = 0;
    f_x = x; f_y = y; f_color = c; f_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk_vga);
      if (f_ready) begin ok = 1; break; end
    end
    @(posedge clk_vga); #1;
    f_valid = 1'b0;
    if (!ok) check("push_f_timeout", 0, 1);
  endtask

  task automatic set_s_pix(input int i);
    s_x = 11'(i); s_y = 11'd1; s_color = 24'h100000 + 24'(i);
  endtask

  // wait for busy_clear to fall on dut_s; returns the cycle it was seen low
  task automatic wait_s_clear_done(input string tag, output int fall_cyc);
    bit ok = 0;
    fall_cyc = 0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk_vga);
      if (!s_busy) begin ok = 1; fall_cyc = cyc; break; end
    end
    if (!ok) check(tag, 0, 1);
  endtask

  task automatic check_clear(input string tag, input int first, input logic bank);
    int bad = 0;
    for (int i = 0; i < 480; i++) begin
      if (first + i >= sq.size()) bad++;
      else if (sq[first+i].addr != 19'(i) || sq[first+i].data != 24'd0 ||
               sq[first+i].bank != bank) bad++;
    end
    check(tag, bad, 0);
  endtask

  initial begin
    int fall_cyc, acc, full_acc, bad;
    bit ok;
    reset_n = 1'b0;
    s_hold = 0; s_valid = 0; s_x = 0; s_y = 0; s_color = 0; s_mem_ready = 1;
    f_hold = 0; f_valid = 0; f_x = 0; f_y = 0; f_color = 0; f_mem_ready = 1;
    tick(3);
    @(negedge clk_vga);
    check("rst_pix_ready", s_ready, 0);
    check("rst_wr_en",     s_wr_en, 0);
    check("rst_bank",      s_bank, 0);
    check("rst_addr",      s_addr, 0);
    check("rst_wdata",     s_wdata, 0);
    check("rst_busy",      s_busy, 0);
    check("rst_dropped",   s_dropped, 0);
    check("rst_overrun",   s_overrun, 0);
    @(posedge clk_vga); #1;
    reset_n = 1'b1;
    tick(2);
    @(negedge clk_vga);
    check("post_rst_ready", f_ready, 1);
    check("post_rst_bank",  f_bank, 1);

    // T1: single pixel, 3-cycle latency, address 2*720+10
    fq.delete();
    @(posedge clk_vga); #1;
    push_f(11'd10, 11'd2, 24'hFF8000);
    @(negedge clk_vga); check("t1_lat_c1", f_wr_en, 0);
    @(negedge clk_vga); check("t1_lat_c2", f_wr_en, 0);
    @(negedge clk_vga); check("t1_lat_c3", f_wr_en, 1);
    check("t1_addr", f_addr, 1450);
    check("t1_data", f_wdata, 24'hFF8000);
    check("t1_bank", f_bank, 1);
    @(negedge clk_vga); check("t1_wr_done", f_wr_en, 0);
    tick(5);
    check("t1_nwrites", fq.size(), 1);

    // T4: range edges on full geometry
    fq.delete();
    push_f(11'd720, 11'd0,   24'hAAAAAA);
    push_f(11'd0,   11'd720, 24'hBBBBBB);
    push_f(11'd719, 11'd719, 24'h0C0C0C);
    tick(20);
    check("t4_nwrites", fq.size(), 1);
    if (fq.size() > 0) begin
      check("t4_addr", fq[0].addr, 518399);
      check("t4_data", fq[0].data, 24'h0C0C0C);
    end
    check("t4_dropped", f_dropped, 2 * STATS);

    // T5: memory backpressure for 5 cycles
    fq.delete();
    f_mem_ready = 1'b0;
    push_f(11'd5, 11'd1, 24'h123456);
    ok = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_vga);
      if (f_wr_en) begin ok = 1; break; end
    end
    check("t5_wr_seen", ok, 1);
    check("t5_addr", f_addr, 725);
    bad = 0;
    repeat (5) begin
      @(negedge clk_vga);
      if (!f_wr_en || f_addr != 19'd725 || f_wdata != 24'h123456) bad++;
    end
    check("t5_stable", bad, 0);
    check("t5_none_yet", fq.size(), 0);
    @(posedge clk_vga); #1;
    f_mem_ready = 1'b1;
    tick(10);
    check("t5_nwrites", fq.size(), 1);
    if (fq.size() > 0) check("t5_wr_addr", fq[0].addr, 725);
    check("t5_wr_en_idle", f_wr_en, 0);

    // T2: full clear of the small bank after hold_frame 0->1
    sq.delete();
    @(posedge clk_vga); #1;
    s_hold = 1'b1;
    @(negedge clk_vga); check("t2_busy_pre", s_busy, 0);
    @(negedge clk_vga);
    check("t2_busy", s_busy, 1);
    check("t2_bank", s_bank, 0);
    check("t2_wr_en", s_wr_en, 1);
    wait_s_clear_done("t2_clear_timeout", fall_cyc);
    check("t2_nwrites", sq.size(), 480);
    check_clear("t2_contig", 0, 1'b0);
    if (sq.size() > 0) check("t2_busy_fall", fall_cyc, sq[sq.size()-1].cyc + 1);

    // T3: pixels pushed during a clear (hold 1->0, back bank 1)
    sq.delete();
    @(posedge clk_vga); #1;
    s_hold = 1'b0;
    @(negedge clk_vga);
    @(negedge clk_vga);
    check("t3_busy", s_busy, 1);
    @(posedge clk_vga); #1;
    acc = 0; full_acc = -1;
    set_s_pix(0);
    s_valid = 1'b1;
    for (int k = 0; k < 3000 && acc < 20; k++) begin
      @(negedge clk_vga);
      if (!s_ready && s_busy && full_acc < 0) full_acc = acc;
      if (s_ready) begin
        @(posedge clk_vga); #1;
        acc++;
        set_s_pix(acc);
      end else begin
        @(posedge clk_vga); #1;
      end
    end
    s_valid = 1'b0;
    check("t3_full_at", full_acc, 16);
    check("t3_accepted", acc, 20);
    for (int k = 0; k < 500 && sq.size() < 500; k++) @(negedge clk_vga);
    tick(10);
    check("t3_nwrites", sq.size(), 500);
    check_clear("t3_clear_contig", 0, 1'b1);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (480 + i >= sq.size()) bad++;
      else if (sq[480+i].bank != 1'b1 || sq[480+i].addr != 19'(24 + i) ||
               sq[480+i].data != 24'h100000 + 24'(i)) bad++;
    end
    check("t3_pixels_in_order", bad, 0);
    check("t3_no_overrun", s_overrun, 0);

    // T6: swap mid-clear at address 100
    sq.delete();
    @(posedge clk_vga); #1;
    s_hold = 1'b1;
    ok = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk_vga);
      if (s_busy && s_addr == 19'd100) begin ok = 1; break; end
    end
    check("t6_reach_100", ok, 1);
    @(posedge clk_vga); #1;
    s_hold = 1'b0;
    @(posedge clk_vga); #1;
    sq.delete();
    @(negedge clk_vga);
    check("t6_overrun", s_overrun, STATS);
    check("t6_bank", s_bank, 1);
    check("t6_restart_addr", s_addr, 0);
    check("t6_busy", s_busy, 1);
    wait_s_clear_done("t6_clear_timeout", fall_cyc);
    check("t6_nwrites", sq.size(), 480);
    check_clear("t6_contig", 0, 1'b1);
    tick(3);
    check("t6_overrun_sticky", s_overrun, STATS);
    check("t6_dropped_s", s_dropped, 0);

    // async reset in the middle of a clear
    @(posedge clk_vga); #1;
    s_hold = 1'b1;
    tick(5);
    reset_n = 1'b0;
    #2;
    check("arst_busy", s_busy, 0);
    check("arst_wr_en", s_wr_en, 0);
    check("arst_addr", s_addr, 0);
    check("arst_overrun", s_overrun, 0);
    tick(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
